// File: rtl/vga_timing_gen.sv
// Raster timing source: scan position, visible flag, active-low syncs and frame pulse/count.
// Flags are decoded from the next count so they register in step with DrawX/DrawY.
module vga_timing_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic [9:0] nxt_x;
  logic [9:0] nxt_y;
  logic       line_wrap;
  logic       frame_wrap;

  always_comb begin
    line_wrap  = (DrawX == H_LAST);
    frame_wrap = line_wrap && (DrawY == V_LAST);
    nxt_x      = line_wrap ? 10'd0 : DrawX + 10'd1;
    nxt_y      = DrawY;
    if (line_wrap) begin
      nxt_y = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
    end
  end

  // Counter/flag register stage: everything updates together on an enabled edge
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      blank       <= 1'b1;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        DrawX       <= nxt_x;
        DrawY       <= nxt_y;
        blank       <= (nxt_x < H_VIS_L) && (nxt_y < V_VIS_L);
        hs          <= !in_range(nxt_x, HS_BEG, HS_END);
        vs          <= !in_range(nxt_y, VS_BEG, VS_END);
        frame_start <= frame_wrap;
        if (frame_wrap) begin
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced 12x8 raster so whole frames run quickly.
module tb_vga_timing_gen;
  // Reduced timing: line 6+1+2+3 = 12, frame 4+1+2+1 = 8 lines, 96 pixels per frame
  localparam int HT    = 12;
  localparam int VT    = 8;
  localparam int FRAME = HT * VT;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic       pix_en;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic [7:0] frame_count;

  vga_timing_gen #(
    .H_VIS(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .pix_en     (pix_en),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .hs         (hs),
    .vs         (vs),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       b;
    logic       h;
    logic       v;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic w;
  } item_t;

  item_t q[$];
  int    tests = 0;
  int    fails = 0;
  int    hs_low, vs_low, vis_cnt, fs_cnt;
  logic  win = 1'b0;

  int   mx, my, mfc;
  logic mfs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.x  = mx[9:0];
    o.y  = my[9:0];
    o.b  = (mx < 6) && (my < 4);
    o.h  = !((mx >= 7) && (mx <= 8));
    o.v  = !((my >= 5) && (my <= 6));
    o.fs = mfs;
    o.fc = mfc[7:0];
    return o;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mfc = 0; mfs = 1'b0;
  endtask

  // Drive pix_en just after a posedge, let one edge happen, record the expected result.
  task automatic step(input logic en);
    item_t it;
    pix_en = en;
    @(posedge vga_clk);
    mfs = 1'b0;
    if (en) begin
      if (mx == HT - 1) begin
        mx = 0;
        if (my == VT - 1) begin
          my  = 0;
          mfs = 1'b1;
          mfc = (mfc + 1) % 256;
        end else begin
          my = my + 1;
        end
      end else begin
        mx = mx + 1;
      end
    end
    it.o = model_obs();
    it.w = win;
    q.push_back(it);
    #1;
  endtask

  task automatic settle();
    pix_en = 1'b0;
    @(negedge vga_clk);
    #1;
  endtask

  task automatic resume();
    pix_en = 1'b0;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic clear_counts();
    hs_low = 0; vs_low = 0; vis_cnt = 0; fs_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x"},  32'(DrawX), 0);
    chk({tag, "_y"},  32'(DrawY), 0);
    chk({tag, "_blank"}, 32'(blank), 1);
    chk({tag, "_hs"}, 32'(hs), 1);
    chk({tag, "_vs"}, 32'(vs), 1);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_fc"}, 32'(frame_count), 0);
  endtask

  // Monitor: compares every presented cycle against the queued expectation
  always @(negedge vga_clk) begin
    if (q.size() > 0) begin
      item_t e;
      obs_t  a;
      e = q.pop_front();
      a = {DrawX, DrawY, blank, hs, vs, frame_start, frame_count};
      chk("scoreboard", a, e.o);
      if (e.w) begin
        if (hs === 1'b0) hs_low++;
        if (vs === 1'b0) vs_low++;
        if (blank === 1'b1) vis_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    pix_en  = 1'b0;
    model_reset();
    clear_counts();
    #2 reset_n = 1'b0;
    repeat (2) @(negedge vga_clk);
    #1;
    chk_reset_outputs("reset");

    reset_n = 1'b1;
    resume();
    step(1'b0);

    // One full frame at full pixel rate
    clear_counts();
    win = 1'b1;
    repeat (FRAME) step(1'b1);
    win = 1'b0;
    settle();
    chk("frame_hs_low", hs_low, 16);
    chk("frame_vs_low", vs_low, 24);
    chk("frame_visible", vis_cnt, 24);
    chk("frame_fs_pulses", fs_cnt, 1);
    chk("frame_wrap_fs", 32'(frame_start), 1);
    chk("frame_wrap_fc", 32'(frame_count), 1);
    chk("frame_wrap_x", 32'(DrawX), 0);
    chk("frame_wrap_y", 32'(DrawY), 0);

    // Half-rate enable: every count held two cycles, frame spans 2*FRAME cycles
    resume();
    clear_counts();
    win = 1'b1;
    repeat (FRAME) begin
      step(1'b1);
      step(1'b0);
    end
    win = 1'b0;
    settle();
    chk("half_hs_low", hs_low, 32);
    chk("half_vs_low", vs_low, 48);
    chk("half_fs_pulses", fs_cnt, 1);
    chk("half_fc", 32'(frame_count), 2);

    // Asynchronous reset in the middle of an hsync pulse
    resume();
    while (!(mx == 8 && my == 2)) step(1'b1);
    settle();
    chk("pre_rst_hs", 32'(hs), 0);
    chk("pre_rst_x", 32'(DrawX), 8);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    q.delete();
    model_reset();
    pix_en = 1'b1;
    @(posedge vga_clk);
    #1;
    chk("held_in_reset_x", 32'(DrawX), 0);
    pix_en = 1'b0;
    @(negedge vga_clk);
    #1;
    reset_n = 1'b1;
    resume();
    step(1'b1);

    // 256 frames: frame_count wraps to 0 together with frame_start
    clear_counts();
    win = 1'b1;
    repeat (255 * FRAME) step(1'b1);
    win = 1'b0;
    settle();
    chk("fc_255", 32'(frame_count), 255);
    chk("fs_pulses_255", fs_cnt, 255);
    resume();
    repeat (FRAME - 1) step(1'b1);
    settle();
    chk("fc_wrap", 32'(frame_count), 0);
    chk("fs_at_wrap", 32'(frame_start), 1);
    chk("wrap_x", 32'(DrawX), 0);
    chk("wrap_y", 32'(DrawY), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
